// File: rtl/softmax_vec_feeder_pkg.sv
// Shared types and defaults for the softmax vector feeder.
// NMAX is the largest vector the engine can address (2**ADDRSIZE-1 elements).
package softmax_feeder_pkg;

   localparam int unsigned DATAWIDTH_DEF = 16;
   localparam int unsigned ADDRSIZE_DEF  = 4;
   localparam int unsigned TIMEOUT_DEF   = 256;
   localparam int unsigned NMAX_DEF      = (1 << ADDRSIZE_DEF) - 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INIT,
      START,
      RUN,
      DRAIN
   } state_t;

   function automatic int unsigned nmax(input int unsigned addrsize);
      return (1 << addrsize) - 1;
   endfunction

endpackage

// File: rtl/softmax_vec_feeder_if.sv
// Valid/ready element stream with an end-of-vector marker.
// The master drives valid/data/last; the slave drives ready.
interface softmax_vec_feeder_if #(
   parameter int unsigned DATAWIDTH = 16
);
   logic                 valid;
   logic [DATAWIDTH-1:0] data;
   logic                 last;
   logic                 ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/softmax_vec_feeder_regfile.sv
// Small register file: one synchronous write port, NREAD asynchronous read ports.
// Contents are never reset.
module feeder_regfile #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRSIZE  = 4,
   parameter int unsigned NREAD     = 3
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDRSIZE-1:0]  waddr,
   input  logic [DATAWIDTH-1:0] wdata,
   input  logic [ADDRSIZE-1:0]  raddr [NREAD],
   output logic [DATAWIDTH-1:0] rdata [NREAD]
);
   logic [DATAWIDTH-1:0] mem [2**ADDRSIZE];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      for (int unsigned i = 0; i < NREAD; i++) rdata[i] = mem[raddr[i]];
   end
endmodule

// File: rtl/softmax_vec_feeder.sv
// Memory-side feeder for the softmax engine: buffers one vector, sequences init/start, captures and drains results.
// Optional RUN watchdog enabled by defining SOFTMAX_FEEDER_TIMEOUT_EN.
module softmax_vec_feeder
   import softmax_feeder_pkg::*;
#(
   parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
   parameter int unsigned ADDRSIZE  = ADDRSIZE_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   softmax_vec_feeder_if.slave     in_str,
   output logic                    sm_init,
   output logic                    sm_start,
   output logic [ADDRSIZE-1:0]     sm_start_addr,
   output logic [ADDRSIZE-1:0]     sm_end_addr,
   input  logic [ADDRSIZE-1:0]     sm_addr,
   input  logic [ADDRSIZE-1:0]     sm_sub0_addr,
   input  logic [ADDRSIZE-1:0]     sm_sub1_addr,
   output logic [DATAWIDTH-1:0]    sm_inp,
   output logic [DATAWIDTH-1:0]    sm_sub0_inp,
   output logic [DATAWIDTH-1:0]    sm_sub1_inp,
   input  logic [DATAWIDTH-1:0]    sm_outp0,
   input  logic                    sm_done,
   softmax_vec_feeder_if.master    out_str,
   output logic                    busy,
   output logic                    err
);
   localparam logic [ADDRSIZE-1:0] NMAX = ADDRSIZE'(nmax(ADDRSIZE));

   if (TIMEOUT == 0) begin : g_timeout_chk
      $error("TIMEOUT must be non-zero");
   end

   state_t              state, state_nxt;
   logic [ADDRSIZE-1:0] wr_ptr, cap_ptr, rd_ptr, n;
   logic                done_q;
   logic                accept, last_beat, fall, wdog_hit, res_we, drain_end;

   logic [ADDRSIZE-1:0]  in_raddr  [3];
   logic [DATAWIDTH-1:0] in_rdata  [3];
   logic [ADDRSIZE-1:0]  res_raddr [1];
   logic [DATAWIDTH-1:0] res_rdata [1];

   assign accept    = in_str.valid & in_str.ready;
   assign last_beat = in_str.last | (wr_ptr == NMAX - 1'b1);
   // done_q only tracks sm_done seen in RUN, so a stale strobe cannot fake a falling edge
   assign fall      = (state == RUN) & done_q & ~sm_done;
   assign res_we    = (state == RUN) & sm_done & (cap_ptr < n);
   assign drain_end = (state == DRAIN) &
                      ((cap_ptr == '0) | (out_str.valid & out_str.ready & out_str.last));

`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wdog_cnt;

   always_ff @(posedge clk) begin
      if (!reset || !(state inside {START, RUN}) || sm_done) wdog_cnt <= '0;
      else                                                    wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_hit = (state inside {START, RUN}) & ~sm_done & (wdog_cnt == WDW'(TIMEOUT - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   feeder_regfile #(.DATAWIDTH(DATAWIDTH), .ADDRSIZE(ADDRSIZE), .NREAD(3)) u_in_bank (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_str.data),
      .raddr (in_raddr),
      .rdata (in_rdata)
   );

   feeder_regfile #(.DATAWIDTH(DATAWIDTH), .ADDRSIZE(ADDRSIZE), .NREAD(1)) u_res_bank (
      .clk   (clk),
      .we    (res_we),
      .waddr (cap_ptr),
      .wdata (sm_outp0),
      .raddr (res_raddr),
      .rdata (res_rdata)
   );

   assign in_raddr[0]  = sm_addr;
   assign in_raddr[1]  = sm_sub0_addr;
   assign in_raddr[2]  = sm_sub1_addr;
   assign sm_inp       = in_rdata[0];
   assign sm_sub0_inp  = in_rdata[1];
   assign sm_sub1_inp  = in_rdata[2];
   assign res_raddr[0] = rd_ptr;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, LOAD: if (accept) state_nxt = last_beat ? INIT : LOAD;
         INIT:       state_nxt = START;
         START:      state_nxt = wdog_hit ? DRAIN : RUN;
         RUN:        if (wdog_hit || fall) state_nxt = DRAIN;
         DRAIN:      if (drain_end) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_str.ready  = 1'b0;
      sm_init       = 1'b0;
      sm_start      = 1'b0;
      out_str.valid = 1'b0;
      busy          = (state != IDLE);
      unique case (state)
         IDLE, LOAD: in_str.ready  = (wr_ptr < NMAX);
         INIT:       sm_init       = 1'b1;
         START:      sm_start      = 1'b1;
         DRAIN:      out_str.valid = (cap_ptr != '0);
         default:    ;
      endcase
   end

   assign out_str.last  = out_str.valid & (rd_ptr == cap_ptr - 1'b1);
   assign out_str.data  = out_str.valid ? res_rdata[0] : '0;
   assign sm_start_addr = '0;
   assign sm_end_addr   = n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         cap_ptr <= '0;
         rd_ptr  <= '0;
         n       <= '0;
         err     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= sm_done & (state == RUN);
         unique case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (state == IDLE) err <= 1'b0;
                  if (last_beat) n <= wr_ptr + 1'b1;
               end
            end
            RUN: begin
               if (sm_done) begin
                  if (cap_ptr < n) cap_ptr <= cap_ptr + 1'b1;
                  else             err     <= 1'b1;
               end
               if (fall && (cap_ptr != n)) err <= 1'b1;
            end
            DRAIN: begin
               if (drain_end) begin
                  wr_ptr  <= '0;
                  cap_ptr <= '0;
                  rd_ptr  <= '0;
               end else if (out_str.valid && out_str.ready) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            default: ;
         endcase
         if (wdog_hit) err <= 1'b1;
      end
   end
endmodule
